// File: rtl/tag_data_arb.sv
// tag_data_arb
//
// Packet-atomic round-robin arbiter sharing the single AXI-stream write port
// of the tag data buffer between NUM_SRC tag-processing pipelines. A source
// keeps the grant until its tlast beat is accepted, so packets never
// interleave in the buffer. The output stage is a single registered beat.
//
// Optional feature macro: TAG_DATA_ARB_TIMEOUT_EN
//   When defined, a mid-packet stall counter aborts a packet whose granted
//   source has been silent for TIMEOUT_CYCLES cycles: a zero tlast beat is
//   emitted to close the buffer packet and timeout_err[src] is set (sticky).
//   When undefined, the grant is held indefinitely and timeout_err is 0.
//
// Ports:
//   clk, rst_n          core clock (rising edge), async active-low reset
//   s_axis_t*           NUM_SRC packed slave streams, source i in slice i
//   m_axis_t*           registered master stream towards the buffer
//   grant               one-hot current grant, zero while idle
//   pkt_cnt             packets forwarded (wraps at 16 bits)
//   timeout_err         sticky per-source stall-abort flags
module tag_data_arb #(
  parameter int NUM_SRC        = 4,
  parameter int NUM_TAGS       = 20,
  parameter int DATA_WIDTH     = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_SRC-1:0]             s_axis_tvalid,
  output logic [NUM_SRC-1:0]             s_axis_tready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_SRC*NUM_TAGS-1:0]    s_axis_tuser,
  input  logic [NUM_SRC-1:0]             s_axis_tlast,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [NUM_TAGS-1:0]            m_axis_tuser,
  output logic                           m_axis_tlast,
  output logic [NUM_SRC-1:0]             grant,
  output logic [15:0]                    pkt_cnt,
  output logic [NUM_SRC-1:0]             timeout_err
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  if (NUM_SRC < 2 || NUM_SRC > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("tag_data_arb: NUM_SRC must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   ptr, ptr_next;
  logic [IDX_W-1:0]   sel, sel_next;      // index of the granted source
  logic [NUM_SRC-1:0] grant_next;

  logic               found;
  logic [IDX_W-1:0]   pick, cand;

  logic               out_ready;          // output register can take a beat
  logic               accept;             // granted beat accepted this cycle
  logic               abort;              // stall timeout closes the packet
  logic               stall_hit;
  logic               load;
  logic               pkt_inc;

  logic [DATA_WIDTH-1:0] src_data [NUM_SRC];
  logic [NUM_TAGS-1:0]   src_user [NUM_SRC];

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
    assign src_data[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign src_user[gi] = s_axis_tuser[gi*NUM_TAGS +: NUM_TAGS];
  end

  assign out_ready = ~m_axis_tvalid | m_axis_tready;

  // Once the stall limit is hit the source is locked out until the abort
  // beat has been placed in the output register.
  assign accept = (state == GRANT) & s_axis_tvalid[sel] & out_ready & ~stall_hit;

  assign s_axis_tready = ((state == GRANT) && out_ready && !stall_hit) ? grant : '0;

  // Round-robin search starting at ptr.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_SRC);
      if (!found && s_axis_tvalid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    sel_next   = sel;
    grant_next = grant;
    load       = 1'b0;
    abort      = 1'b0;
    pkt_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          sel_next   = pick;
          grant_next = NUM_SRC'(1) << pick;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          load = 1'b1;
          if (s_axis_tlast[sel]) begin
            state_next = IDLE;
            grant_next = '0;
            ptr_next   = (sel == IDX_W'(NUM_SRC - 1)) ? '0 : sel + IDX_W'(1);
            pkt_inc    = 1'b1;
          end
        end else if (stall_hit && out_ready) begin
          abort      = 1'b1;
          state_next = IDLE;
          grant_next = '0;
          ptr_next   = (sel == IDX_W'(NUM_SRC - 1)) ? '0 : sel + IDX_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
      grant <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      sel   <= sel_next;
      grant <= grant_next;
    end
  end

  // Output register: loads on an accepted beat (or the abort beat), otherwise
  // drains on m_axis_tready. Payload is only rewritten on a load, so it stays
  // stable while the buffer back-pressures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
      pkt_cnt       <= '0;
    end else begin
      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= src_data[sel];
        m_axis_tuser  <= src_user[sel];
        m_axis_tlast  <= s_axis_tlast[sel];
      end else if (abort) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= '0;
        m_axis_tuser  <= '0;
        m_axis_tlast  <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (pkt_inc) begin
        pkt_cnt <= pkt_cnt + 16'd1;
      end
    end
  end

`ifdef TAG_DATA_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] stall;

  assign stall_hit = (state == GRANT) && (stall == STALL_W'(TIMEOUT_CYCLES));

  // Counts only cycles where the granted source is silent; back-pressure
  // from the buffer neither counts nor clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall       <= '0;
      timeout_err <= '0;
    end else begin
      if (state != GRANT || accept) begin
        stall <= '0;
      end else if (!s_axis_tvalid[sel] && !stall_hit) begin
        stall <= stall + STALL_W'(1);
      end
      if (abort) begin
        timeout_err <= timeout_err | grant;
      end
    end
  end
`else
  assign stall_hit   = 1'b0;
  assign timeout_err = '0;
`endif

endmodule

// File: tb/tb_tag_data_arb.sv
// tb_tag_data_arb
//
// Bench for tag_data_arb: a table of directed cycle vectors, hand-written
// sequences for asynchronous reset and mid-packet stall, and a randomized
// phase compared each cycle against a transaction-level reference model.
// Build with TAG_DATA_ARB_TIMEOUT_EN defined to exercise the stall abort.
module tb_tag_data_arb;

  localparam int N  = 4;
  localparam int NT = 20;
  localparam int DW = 256;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  s_tvalid, s_tready, s_tlast;
  logic [N*DW-1:0] s_tdata;
  logic [N*NT-1:0] s_tuser;
  logic          m_tvalid, m_tready, m_tlast;
  logic [DW-1:0] m_tdata;
  logic [NT-1:0] m_tuser;
  logic [N-1:0]  grant, timeout_err;
  logic [15:0]   pkt_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tag_data_arb #(
    .NUM_SRC(N), .NUM_TAGS(NT), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast),
    .grant(grant), .pkt_cnt(pkt_cnt), .timeout_err(timeout_err)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [NT-1:0] user_of(input int src, input logic [7:0] d);
    return NT'(((src + 1) << 12) | int'(d));
  endfunction

  function automatic logic [DW-1:0] data_of(input int src, input logic [7:0] d);
    return DW'({d, 8'(src)});
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    r = '0;
    for (int w = 0; w < DW / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic do_reset();
    rst_n    = 1'b0;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    s_tuser  = '0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Every source presents data byte d tagged with its own index.
  task automatic drive_dir(input logic [N-1:0] v, input logic [N-1:0] l,
                           input logic mr, input logic [7:0] d);
    s_tvalid = v;
    s_tlast  = l;
    m_tready = mr;
    for (int i = 0; i < N; i++) begin
      s_tdata[i*DW +: DW] = data_of(i, d);
      s_tuser[i*NT +: NT] = user_of(i, d);
    end
  endtask

  // One vector = inputs held across one clock edge. esr is the expected
  // s_tready before the edge; the remaining expectations are after it.
  typedef struct {
    bit           rst;
    logic [N-1:0] v, l;
    bit           mr;
    logic [7:0]   d;
    logic [N-1:0] esr, eg;
    int           epkt;
    bit           emv, eml;
    int           esrc;
    logic [7:0]   ed;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input logic [N-1:0] v, input logic [N-1:0] l,
                     input bit mr, input logic [7:0] d, input logic [N-1:0] esr,
                     input logic [N-1:0] eg, input int epkt, input bit emv,
                     input bit eml, input int esrc, input logic [7:0] ed);
    vec_t e;
    e.rst = rst; e.v = v; e.l = l; e.mr = mr; e.d = d; e.esr = esr; e.eg = eg;
    e.epkt = epkt; e.emv = emv; e.eml = eml; e.esrc = esrc; e.ed = ed;
    tbl.push_back(e);
  endtask

  // Reference model state (transaction level: owner index, pointer, one
  // output slot, counters).
  int           own, mptr, mcnt, mstall;
  bit           mov, mol;
  logic [DW-1:0] mod;
  logic [NT-1:0] mou;
  logic [N-1:0] merr;
  logic [DW-1:0] rd [N];
  logic [NT-1:0] ru [N];
  int           left [N];

  function automatic bit model_hit();
    bit h;
    h = 1'b0;
`ifdef TAG_DATA_ARB_TIMEOUT_EN
    h = (own >= 0) && (mstall >= TO);
`endif
    return h;
  endfunction

  task automatic new_beat(input int i, input bit new_pkt);
    rd[i] = rnd_data();
    ru[i] = NT'($urandom);
    if (new_pkt) left[i] = $urandom_range(1, 4);
  endtask

  task automatic model_step();
    bit ordy;
    int acc;
    bit abrt;
    ordy = !mov || m_tready;
    acc  = -1;
    abrt = 1'b0;
    if (own < 0) begin
      for (int k = 0; k < N; k++) begin
        if (own < 0 && s_tvalid[(mptr + k) % N]) begin
          own    = (mptr + k) % N;
          mstall = 0;
        end
      end
    end else if (model_hit()) begin
      abrt = ordy;
    end else if (s_tvalid[own] && ordy) begin
      acc = own;
    end else if (!s_tvalid[own]) begin
      mstall++;
    end
    if (acc >= 0) begin
      mov = 1'b1; mod = rd[acc]; mou = ru[acc]; mol = s_tlast[acc];
      mstall = 0;
      if (mol) begin
        mcnt = (mcnt + 1) % 65536;
        mptr = (acc + 1) % N;
        own  = -1;
      end
      left[acc]--;
      new_beat(acc, left[acc] == 0);
    end else if (abrt) begin
      mov = 1'b1; mod = '0; mou = '0; mol = 1'b1;
      merr[own] = 1'b1;
      mptr = (own + 1) % N;
      own  = -1;
    end else if (m_tready) begin
      mov = 1'b0;
    end
  endtask

  logic [N-1:0] exp_sr;
  bit           seen;
  logic [DW-1:0] seen_data;
  logic [NT-1:0] seen_user;

  initial begin
    // Test 1: sources 0 and 2, 3-beat packets each.
    add(1, 4'b0101, 4'b0000, 1, 1, 4'b0000, 4'b0001, 0, 0, 0, 0, 0);
    add(0, 4'b0101, 4'b0000, 1, 1, 4'b0001, 4'b0001, 0, 1, 0, 0, 1);
    add(0, 4'b0101, 4'b0000, 1, 2, 4'b0001, 4'b0001, 0, 1, 0, 0, 2);
    add(0, 4'b0101, 4'b0001, 1, 3, 4'b0001, 4'b0000, 1, 1, 1, 0, 3);
    add(0, 4'b0100, 4'b0000, 1, 1, 4'b0000, 4'b0100, 1, 0, 0, 0, 0);
    add(0, 4'b0100, 4'b0000, 1, 1, 4'b0100, 4'b0100, 1, 1, 0, 2, 1);
    add(0, 4'b0100, 4'b0000, 1, 2, 4'b0100, 4'b0100, 1, 1, 0, 2, 2);
    add(0, 4'b0100, 4'b0100, 1, 3, 4'b0100, 4'b0000, 2, 1, 1, 2, 3);
    add(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 2, 0, 0, 0, 0);
    // Test 2: all sources, continuous single-beat packets.
    add(1, 4'b1111, 4'b1111, 1, 1, 4'b0000, 4'b0001, 0, 0, 0, 0, 0);
    add(0, 4'b1111, 4'b1111, 1, 1, 4'b0001, 4'b0000, 1, 1, 1, 0, 1);
    add(0, 4'b1111, 4'b1111, 1, 1, 4'b0000, 4'b0010, 1, 0, 0, 0, 0);
    add(0, 4'b1111, 4'b1111, 1, 1, 4'b0010, 4'b0000, 2, 1, 1, 1, 1);
    add(0, 4'b1111, 4'b1111, 1, 1, 4'b0000, 4'b0100, 2, 0, 0, 0, 0);
    add(0, 4'b1111, 4'b1111, 1, 1, 4'b0100, 4'b0000, 3, 1, 1, 2, 1);
    add(0, 4'b1111, 4'b1111, 1, 1, 4'b0000, 4'b1000, 3, 0, 0, 0, 0);
    add(0, 4'b1111, 4'b1111, 1, 1, 4'b1000, 4'b0000, 4, 1, 1, 3, 1);
    add(0, 4'b1111, 4'b1111, 1, 1, 4'b0000, 4'b0001, 4, 0, 0, 0, 0);
    add(0, 4'b1111, 4'b1111, 1, 1, 4'b0001, 4'b0000, 5, 1, 1, 0, 1);
    // Test 3: source 1, 4 beats, m_tready toggling.
    add(1, 4'b0010, 4'b0000, 1, 1, 4'b0000, 4'b0010, 0, 0, 0, 0, 0);
    add(0, 4'b0010, 4'b0000, 0, 1, 4'b0010, 4'b0010, 0, 1, 0, 1, 1);
    add(0, 4'b0010, 4'b0000, 1, 2, 4'b0010, 4'b0010, 0, 1, 0, 1, 2);
    add(0, 4'b0010, 4'b0000, 0, 3, 4'b0000, 4'b0010, 0, 1, 0, 1, 2);
    add(0, 4'b0010, 4'b0000, 1, 3, 4'b0010, 4'b0010, 0, 1, 0, 1, 3);
    add(0, 4'b0010, 4'b0000, 0, 4, 4'b0000, 4'b0010, 0, 1, 0, 1, 3);
    add(0, 4'b0010, 4'b0010, 1, 4, 4'b0010, 4'b0000, 1, 1, 1, 1, 4);
    add(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 1, 1, 1, 4);
    add(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0);
    // Test 4: source 3 requests in the middle of source 0's packet.
    add(1, 4'b0001, 4'b0000, 1, 1, 4'b0000, 4'b0001, 0, 0, 0, 0, 0);
    add(0, 4'b1001, 4'b1000, 1, 1, 4'b0001, 4'b0001, 0, 1, 0, 0, 1);
    add(0, 4'b1001, 4'b1000, 1, 2, 4'b0001, 4'b0001, 0, 1, 0, 0, 2);
    add(0, 4'b1001, 4'b1001, 1, 3, 4'b0001, 4'b0000, 1, 1, 1, 0, 3);
    add(0, 4'b1000, 4'b1000, 1, 7, 4'b0000, 4'b1000, 1, 0, 0, 0, 0);
    add(0, 4'b1000, 4'b1000, 1, 7, 4'b1000, 4'b0000, 2, 1, 1, 3, 7);
    add(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 2, 0, 0, 0, 0);

    // Reset state.
    do_reset();
    check("rst_grant", 256'(grant), 256'(0));
    check("rst_mvalid", 256'(m_tvalid), 256'(0));
    check("rst_mdata", 256'(m_tdata), 256'(0));
    check("rst_muser", 256'(m_tuser), 256'(0));
    check("rst_mlast", 256'(m_tlast), 256'(0));
    check("rst_pkt", 256'(pkt_cnt), 256'(0));
    check("rst_err", 256'(timeout_err), 256'(0));
    check("rst_sready", 256'(s_tready), 256'(0));

    foreach (tbl[k]) begin
      if (tbl[k].rst) do_reset();
      drive_dir(tbl[k].v, tbl[k].l, tbl[k].mr, tbl[k].d);
      #1;
      check($sformatf("row%0d_sready", k), 256'(s_tready), 256'(tbl[k].esr));
      @(posedge clk);
      #1;
      check($sformatf("row%0d_grant", k), 256'(grant), 256'(tbl[k].eg));
      check($sformatf("row%0d_pkt", k), 256'(pkt_cnt), 256'(tbl[k].epkt));
      check($sformatf("row%0d_mvalid", k), 256'(m_tvalid), 256'(tbl[k].emv));
      if (tbl[k].emv) begin
        check($sformatf("row%0d_mlast", k), 256'(m_tlast), 256'(tbl[k].eml));
        check($sformatf("row%0d_mdata", k), 256'(m_tdata), 256'(data_of(tbl[k].esrc, tbl[k].ed)));
        check($sformatf("row%0d_muser", k), 256'(m_tuser), 256'(user_of(tbl[k].esrc, tbl[k].ed)));
      end
      $display("row %0d grant=%b mvalid=%b mlast=%b pkt_cnt=%0d", k, grant, m_tvalid, m_tlast, pkt_cnt);
    end

    // Asynchronous reset in the middle of a packet.
    do_reset();
    drive_dir(4'b0001, 4'b0001, 1, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive_dir(4'b0001, 4'b0000, 1, 1);
    @(posedge clk); #1;
    drive_dir(4'b0001, 4'b0000, 1, 2);
    @(posedge clk); #1;
    check("arst_pre_pkt", 256'(pkt_cnt), 256'(1));
    check("arst_pre_mvalid", 256'(m_tvalid), 256'(1));
    check("arst_pre_grant", 256'(grant), 256'(4'b0001));
    #2 rst_n = 1'b0;
    #1;
    check("arst_grant", 256'(grant), 256'(0));
    check("arst_mvalid", 256'(m_tvalid), 256'(0));
    check("arst_mdata", 256'(m_tdata), 256'(0));
    check("arst_mlast", 256'(m_tlast), 256'(0));
    check("arst_sready", 256'(s_tready), 256'(0));
    check("arst_pkt", 256'(pkt_cnt), 256'(0));
    #2 rst_n = 1'b1;
    drive_dir(4'b0110, 4'b0110, 1, 5);
    @(posedge clk); #1;
    check("arst_ptr_grant", 256'(grant), 256'(4'b0010));
    $display("async reset sequence grant=%b pkt_cnt=%0d", grant, pkt_cnt);

    // Source 1 stalls after two beats while sources 0 and 2 wait.
    do_reset();
    drive_dir(4'b0010, 4'b0000, 1, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive_dir(4'b0010, 4'b0000, 1, 2);
    @(posedge clk); #1;
    drive_dir(4'b0101, 4'b0101, 1, 9);
    seen = 1'b0;
    seen_data = '1;
    seen_user = '1;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge clk); #1;
      if (m_tvalid && m_tlast) begin
        seen = 1'b1;
        seen_data = m_tdata;
        seen_user = m_tuser;
      end
    end
`ifdef TAG_DATA_ARB_TIMEOUT_EN
    check("to_seen", 256'(seen), 256'(1));
    check("to_data", 256'(seen_data), 256'(0));
    check("to_user", 256'(seen_user), 256'(0));
    check("to_err", 256'(timeout_err), 256'(4'b0010));
    check("to_pkt", 256'(pkt_cnt), 256'(0));
    @(posedge clk); #1;
    check("to_next_grant", 256'(grant), 256'(4'b0100));
`else
    check("hold_seen", 256'(seen), 256'(0));
    check("hold_grant", 256'(grant), 256'(4'b0010));
    check("hold_err", 256'(timeout_err), 256'(0));
    check("hold_pkt", 256'(pkt_cnt), 256'(0));
`endif
    $display("stall sequence tlast_seen=%0d grant=%b timeout_err=%b", seen, grant, timeout_err);

    // Randomized traffic against the reference model.
    do_reset();
    own = -1; mptr = 0; mcnt = 0; mstall = 0;
    mov = 1'b0; mol = 1'b0; mod = '0; mou = '0; merr = '0;
    for (int i = 0; i < N; i++) new_beat(i, 1'b1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        s_tvalid[i] = ($urandom_range(0, 3) != 0);
        s_tlast[i]  = (left[i] == 1);
        s_tdata[i*DW +: DW] = rd[i];
        s_tuser[i*NT +: NT] = ru[i];
      end
      m_tready = ($urandom_range(0, 3) != 0);
      #1;
      exp_sr = '0;
      if (own >= 0 && (!mov || m_tready) && !model_hit()) exp_sr[own] = 1'b1;
      check("rnd_sready", 256'(s_tready), 256'(exp_sr));
      @(posedge clk);
      model_step();
      #1;
      check("rnd_grant", 256'(grant), 256'((own >= 0) ? (N'(1) << own) : N'(0)));
      check("rnd_mvalid", 256'(m_tvalid), 256'(mov));
      check("rnd_pkt", 256'(pkt_cnt), 256'(mcnt));
      check("rnd_err", 256'(timeout_err), 256'(merr));
      if (mov) begin
        check("rnd_mdata", 256'(m_tdata), 256'(mod));
        check("rnd_muser", 256'(m_tuser), 256'(mou));
        check("rnd_mlast", 256'(m_tlast), 256'(mol));
      end
    end
    $display("random phase packets=%0d", mcnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
